// File: rtl/ariane_axi_pkg.sv
// Minimal AXI4 channel and bundle types matching the CVA6 ariane_axi naming,
// so the limiter can be compiled stand-alone.
package ariane_axi;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ax_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;

endpackage

// File: rtl/axi_outstanding_limiter_pkg.sv
// Shared types and helpers for the outstanding-transaction limiter.
package axi_outstanding_limiter_pkg;

    typedef enum logic [1:0] {RUN, DRAIN, DRAINED} limiter_state_e;

    function automatic int cnt_w(input int max_cnt);
        return $clog2(max_cnt + 1);
    endfunction

endpackage

// File: rtl/axi_outstanding_limiter_txn.sv
// Saturating up/down transaction counter; underflow is a one-cycle pulse when
// a lone decrement hits an empty counter.
module txn_counter
    import axi_outstanding_limiter_pkg::*;
#(
    parameter int  MaxCnt = 4,
    localparam int W      = cnt_w(MaxCnt)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         full,
    output logic         empty,
    output logic         underflow
);

    assign full      = (cnt == W'(MaxCnt));
    assign empty     = (cnt == '0);
    assign underflow = dec & ~inc & empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (inc && !dec && !full) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && !empty) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/axi_outstanding_limiter.sv
// Caps outstanding AXI reads/writes, offers a drain handshake and flags
// response underflow. Optional watchdog: define AXI_LIMITER_TIMEOUT_EN.
module axi_outstanding_limiter
    import axi_outstanding_limiter_pkg::*;
#(
    parameter int  MaxRdTxn = 4,
    parameter int  MaxWrTxn = 4,
`ifdef AXI_LIMITER_TIMEOUT_EN
    parameter int  TimeoutCycles = 1024,
`endif
    localparam int RdCntW = cnt_w(MaxRdTxn),
    localparam int WrCntW = cnt_w(MaxWrTxn)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  ariane_axi::req_t  slv_req_i,
    output ariane_axi::resp_t slv_resp_o,
    output ariane_axi::req_t  mst_req_o,
    input  ariane_axi::resp_t mst_resp_i,
    input  logic              drain_req_i,
    output logic              drain_ack_o,
    output logic [RdCntW-1:0] rd_cnt_o,
    output logic [WrCntW-1:0] wr_cnt_o,
    output logic              underflow_o,
    output logic              timeout_o
);

    limiter_state_e state_q, state_d;
    logic ar_lock, aw_lock, ar_allow, aw_allow;
    logic ar_hs, aw_hs, r_hs, r_last_hs, b_hs;
    logic rd_full, rd_empty, rd_uf, wr_full, wr_empty, wr_uf;

    // A locked channel keeps its grant so a presented valid is never withdrawn.
    assign ar_allow = ar_lock | ((state_q == RUN) & ~rd_full);
    assign aw_allow = aw_lock | ((state_q == RUN) & ~wr_full);

    always_comb begin
        mst_req_o           = slv_req_i;
        mst_req_o.ar_valid  = slv_req_i.ar_valid & ar_allow;
        mst_req_o.aw_valid  = slv_req_i.aw_valid & aw_allow;
        slv_resp_o          = mst_resp_i;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_allow;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_allow;
    end

    assign ar_hs     = slv_req_i.ar_valid & ar_allow & mst_resp_i.ar_ready;
    assign aw_hs     = slv_req_i.aw_valid & aw_allow & mst_resp_i.aw_ready;
    assign r_hs      = mst_resp_i.r_valid & slv_req_i.r_ready;
    assign r_last_hs = r_hs & mst_resp_i.r.last;
    assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;

    txn_counter #(.MaxCnt(MaxRdTxn)) i_rd_cnt (
        .clk_i, .rst_ni, .inc(ar_hs), .dec(r_last_hs),
        .cnt(rd_cnt_o), .full(rd_full), .empty(rd_empty), .underflow(rd_uf)
    );

    txn_counter #(.MaxCnt(MaxWrTxn)) i_wr_cnt (
        .clk_i, .rst_ni, .inc(aw_hs), .dec(b_hs),
        .cnt(wr_cnt_o), .full(wr_full), .empty(wr_empty), .underflow(wr_uf)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            ar_lock     <= 1'b0;
            aw_lock     <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            ar_lock     <= ar_hs ? 1'b0 : (ar_lock | (mst_req_o.ar_valid & ~mst_resp_i.ar_ready));
            aw_lock     <= aw_hs ? 1'b0 : (aw_lock | (mst_req_o.aw_valid & ~mst_resp_i.aw_ready));
            underflow_o <= underflow_o | rd_uf | wr_uf;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (drain_req_i) state_d = DRAIN;
            DRAIN: begin
                if (!drain_req_i) state_d = RUN;
                else if (rd_empty && wr_empty && !ar_lock && !aw_lock) state_d = DRAINED;
            end
            DRAINED: if (!drain_req_i) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        drain_ack_o = (state_q == DRAINED);
    end

`ifdef AXI_LIMITER_TIMEOUT_EN
    localparam int TmoW = cnt_w(TimeoutCycles);
    logic [TmoW-1:0] wd_cnt;
    logic            wd_clr;

    // Any response shows forward progress; an idle port cannot time out.
    assign wd_clr = r_hs | b_hs | (rd_empty & wr_empty);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt    <= '0;
            timeout_o <= 1'b0;
        end else if (wd_clr) begin
            wd_cnt <= '0;
        end else if (wd_cnt != TmoW'(TimeoutCycles)) begin
            wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt == TmoW'(TimeoutCycles - 1)) timeout_o <= 1'b1;
        end
    end
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_axi_outstanding_limiter.sv
// Scoreboard bench for axi_outstanding_limiter: directed test-plan sequences
// followed by random traffic, all checked against a transaction-level model.
module tb_axi_outstanding_limiter;

    localparam int MAX_RD = 4;
    localparam int MAX_WR = 4;
    localparam int TMO    = 16;
    localparam int M_RUN = 0, M_DRAIN = 1, M_DONE = 2;

    logic clk = 1'b0, rst_n = 1'b0;
    ariane_axi::req_t  slv_req, mst_req;
    ariane_axi::resp_t slv_resp, mst_resp;
    logic drain_req, drain_ack, underflow, timeout;
    logic [2:0] rd_cnt, wr_cnt;

    always #5 clk = ~clk;

    axi_outstanding_limiter #(
        .MaxRdTxn(MAX_RD),
`ifdef AXI_LIMITER_TIMEOUT_EN
        .TimeoutCycles(TMO),
`endif
        .MaxWrTxn(MAX_WR)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .slv_req_i(slv_req), .slv_resp_o(slv_resp),
        .mst_req_o(mst_req), .mst_resp_i(mst_resp),
        .drain_req_i(drain_req), .drain_ack_o(drain_ack),
        .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt),
        .underflow_o(underflow), .timeout_o(timeout)
    );

    typedef struct {
        bit arv, arr, awv, awr, wv, rv, rl, rr, bv, br, drn;
        logic [63:0] addr, data;
    } stim_t;

    typedef struct {
        bit ar_valid, ar_ready, aw_valid, aw_ready, ack, uf, tmo;
        int rd, wr;
        logic [63:0] ar_addr, w_data, r_data;
        logic [3:0]  b_id;
    } exp_t;

    exp_t expq[$];
    int checks = 0, errors = 0;

    // Transaction-level reference: outstanding counts, pending-valid flags, mode.
    int m_rd, m_wr, m_mode, m_tc;
    bit m_arh, m_awh, m_uf, m_tmo;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s = '{default: 0};
        s.rr = 1; s.br = 1;
        return s;
    endfunction

    task automatic model_reset();
        m_rd = 0; m_wr = 0; m_mode = M_RUN; m_tc = 0;
        m_arh = 0; m_awh = 0; m_uf = 0; m_tmo = 0;
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        bit ok_ar, ok_aw, ar_fire, aw_fire, rlast, rany, bfire;
        slv_req = '0; mst_resp = '0;
        slv_req.ar_valid = s.arv; slv_req.ar.addr = s.addr;
        slv_req.aw_valid = s.awv; slv_req.aw.addr = ~s.addr;
        slv_req.w_valid  = s.wv;  slv_req.w.data  = s.data;
        slv_req.r_ready  = s.rr;  slv_req.b_ready = s.br;
        mst_resp.ar_ready = s.arr; mst_resp.aw_ready = s.awr; mst_resp.w_ready = 1'b1;
        mst_resp.r_valid = s.rv; mst_resp.r.last = s.rl; mst_resp.r.data = s.data ^ s.addr;
        mst_resp.b_valid = s.bv; mst_resp.b.id = s.data[3:0];
        drain_req = s.drn;

        ok_ar = m_arh || (m_mode == M_RUN && m_rd < MAX_RD);
        ok_aw = m_awh || (m_mode == M_RUN && m_wr < MAX_WR);
        e.ar_valid = s.arv && ok_ar; e.ar_ready = s.arr && ok_ar;
        e.aw_valid = s.awv && ok_aw; e.aw_ready = s.awr && ok_aw;
        e.rd = m_rd; e.wr = m_wr; e.ack = (m_mode == M_DONE); e.uf = m_uf; e.tmo = m_tmo;
        e.ar_addr = s.addr; e.w_data = s.data; e.r_data = s.data ^ s.addr; e.b_id = s.data[3:0];
        expq.push_back(e);

        ar_fire = e.ar_valid && s.arr;
        aw_fire = e.aw_valid && s.awr;
        rany    = s.rv && s.rr;
        rlast   = rany && s.rl;
        bfire   = s.bv && s.br;
        case (m_mode)
            M_RUN:   if (s.drn) m_mode = M_DRAIN;
            M_DRAIN: if (!s.drn) m_mode = M_RUN;
                     else if (m_rd == 0 && m_wr == 0 && !m_arh && !m_awh) m_mode = M_DONE;
            default: if (!s.drn) m_mode = M_RUN;
        endcase
`ifdef AXI_LIMITER_TIMEOUT_EN
        if (rany || bfire || (m_rd + m_wr == 0)) m_tc = 0;
        else if (m_tc < TMO) begin
            m_tc++;
            if (m_tc == TMO) m_tmo = 1;
        end
`endif
        if (ar_fire && !rlast) m_rd++;
        else if (rlast && !ar_fire) begin if (m_rd == 0) m_uf = 1; else m_rd--; end
        if (aw_fire && !bfire) m_wr++;
        else if (bfire && !aw_fire) begin if (m_wr == 0) m_uf = 1; else m_wr--; end
        if (ar_fire) m_arh = 0; else if (e.ar_valid) m_arh = 1;
        if (aw_fire) m_awh = 0; else if (e.aw_valid) m_awh = 1;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; slv_req = '0; mst_resp = '0; drain_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    // Monitor: compares every presented cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("mst_ar_valid", mst_req.ar_valid, e.ar_valid);
                chk("slv_ar_ready", slv_resp.ar_ready, e.ar_ready);
                chk("mst_aw_valid", mst_req.aw_valid, e.aw_valid);
                chk("slv_aw_ready", slv_resp.aw_ready, e.aw_ready);
                chk("rd_cnt", rd_cnt, e.rd);
                chk("wr_cnt", wr_cnt, e.wr);
                chk("drain_ack", drain_ack, e.ack);
                chk("underflow", underflow, e.uf);
                chk("timeout", timeout, e.tmo);
                chk("ar_addr_pass", mst_req.ar.addr, e.ar_addr);
                chk("w_data_pass", mst_req.w.data, e.w_data);
                chk("r_data_pass", slv_resp.r.data, e.r_data);
                chk("b_id_pass", slv_resp.b.id, e.b_id);
            end
        end
    end

    initial begin
        stim_t s;
        bit drn;
        slv_req = '0; mst_resp = '0; drain_req = 1'b0;
        model_reset();
        do_reset();
        step(idle());
        chk("reset_rd_cnt", rd_cnt, 0);
        chk("reset_ack", drain_ack, 0);

        // Limit: five ARs against a stalled R channel, then one R-last frees a slot.
        s = idle(); s.arv = 1; s.arr = 1; s.addr = 64'h1000;
        repeat (5) step(s);
        chk("limit_rd_cnt", rd_cnt, 4);
        chk("limit_5th_held", slv_resp.ar_ready, 0);
        s.rv = 1; s.rl = 1; step(s);
        s.rv = 0; step(s);
        chk("limit_5th_taken", rd_cnt, 4);
        s = idle(); s.rv = 1; s.rl = 1;
        repeat (4) step(s);

        // Simultaneous AR handshake and R-last keeps the count.
        s = idle(); s.arv = 1; s.arr = 1;
        repeat (2) step(s);
        s.rv = 1; s.rl = 1; step(s);
        chk("simul_rd_cnt", rd_cnt, 2);
        s = idle(); s.rv = 1; s.rl = 1;
        repeat (2) step(s);

        // Drain with two writes outstanding.
        s = idle(); s.awv = 1; s.awr = 1;
        repeat (2) step(s);
        s = idle(); s.drn = 1; step(s);
        s.awv = 1; s.awr = 1;
        repeat (2) step(s);
        chk("drain_no_aw", wr_cnt, 2);
        s = idle(); s.drn = 1; s.bv = 1;
        repeat (2) step(s);
        s.bv = 0; step(s);
        chk("drain_ack_set", drain_ack, 1);
        s = idle(); s.awv = 1; s.awr = 1; step(s);
        chk("drain_ack_clr", drain_ack, 0);
        step(s);
        chk("run_aw_taken", wr_cnt, 1);
        s = idle(); s.bv = 1; step(s);

        // Lock: a presented AR survives drain until its handshake.
        s = idle(); s.arv = 1; step(s);
        s.drn = 1; repeat (3) step(s);
        s.arr = 1; step(s);
        chk("lock_rd_cnt", rd_cnt, 1);
        s = idle(); s.drn = 1; s.arv = 1; s.arr = 1;
        repeat (3) step(s);
        chk("lock_wait_r", drain_ack, 0);
        s = idle(); s.drn = 1; s.rv = 1; s.rl = 1; step(s);
        s.rv = 0; step(s);
        chk("lock_drained", drain_ack, 1);
        step(idle());

        // Underflow: B with nothing outstanding.
        s = idle(); s.bv = 1; step(s);
        repeat (3) step(idle());
        chk("uf_sticky", underflow, 1);
        chk("uf_wr_cnt", wr_cnt, 0);
        do_reset();
        step(idle());
        chk("uf_cleared", underflow, 0);

        // Watchdog: one read left outstanding.
        s = idle(); s.arv = 1; s.arr = 1; step(s);
        repeat (TMO + 2) step(idle());
`ifdef AXI_LIMITER_TIMEOUT_EN
        chk("timeout_set", timeout, 1);
`else
        chk("timeout_off", timeout, 0);
`endif
        do_reset();

        // Random traffic; responses mostly only when something is outstanding.
        drn = 0;
        for (int i = 0; i < 3000; i++) begin
            s = idle();
            if ($urandom_range(99) < 3) drn = ~drn;
            s.drn  = drn;
            s.arv  = $urandom_range(1); s.arr = $urandom_range(1);
            s.awv  = $urandom_range(1); s.awr = $urandom_range(1);
            s.wv   = $urandom_range(1);
            s.rr   = $urandom_range(3) != 0; s.br = $urandom_range(3) != 0;
            s.rv   = (m_rd > 0 || $urandom_range(199) == 0) && $urandom_range(1);
            s.rl   = $urandom_range(1);
            s.bv   = (m_wr > 0 || $urandom_range(199) == 0) && $urandom_range(1);
            s.addr = {$urandom, $urandom}; s.data = {$urandom, $urandom};
            step(s);
        end
        step(idle());
        @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
